shift_seq: RTL and testbench
============================

Name: shift_seq

Overview:
- Multi-cycle shift sequencer for the RV64 ALU. Performs SLL/SRL/SRA, plus the optional RV64 word forms, by applying a small per-cycle shift stage repeatedly.
- Trades latency for area versus a full log2(N)-stage barrel shifter.
- Sits beside the ALU. Issue side and result side each use a valid/ready handshake, so the core stalls while the sequencer is busy.

Parameters:
- N, 64, datapath width (power of 2, >= 32).
- STEP, 8, maximum shift distance applied per cycle (power of 2, 1 <= STEP <= N/2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  request present
- start_ready  out  1  sequencer can accept a request (high only in IDLE)
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved
- word  in  1  RV64 W-variant select (effective only with SHIFT_WORD_OPS_EN)
- shift_amount  in  $clog2(N)  shift distance
- dataIn  in  N  operand
- result_valid  out  1  dataOut valid
- result_ready  in  1  consumer takes result
- dataOut  out  N  result
- busy  out  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE. Internal working register and remaining count clear to 0.
  - Outputs: dataOut=0, result_valid=0, busy=0, start_ready=1.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - start_ready=1.
  - Accept when start_valid && start_ready. On accept, latch the operand, op and amount.
  - If the effective amount is 0, or op=11, go to DONE. Otherwise go to BUSY.
- BUSY:
  - Each cycle, step = min(remaining, STEP). Shift the working register by step: zero fill for SLL/SRL, sign fill for SRA.
  - remaining -= step.
  - When remaining reaches 0, the result is loaded into dataOut and the state goes to DONE on the same edge.
- DONE:
  - result_valid=1. dataOut is stable while result_valid is high.
  - On result_ready, go to IDLE. No accept is possible in that same cycle.
- Latency, counting the cycle after the accept edge as cycle 1:
  - Effective amount 0, or op=11: result_valid in cycle 1.
  - Otherwise: result_valid in cycle 1 + ceil(amount/STEP).
- Throughput: one operation per (latency + 1) cycles at minimum.
- op=11: dataOut = operand unchanged; no error flag.
- dataOut holds its last value after leaving DONE, until the next result is loaded.
- Inputs are ignored outside the accept cycle. Changing them while BUSY has no effect.
- Reset mid-operation aborts the operation. No result is produced.
- Back-pressure: result_ready may stay low indefinitely. The sequencer waits in DONE with result_valid and dataOut held.

Optional Feature:
- Macro: SHIFT_WORD_OPS_EN.
- Defined: when word=1, the amount is masked to 5 bits. The operand is pre-conditioned before shifting:
  - SLL: unchanged.
  - SRL: low 32 bits zero-extended.
  - SRA: low 32 bits sign-extended.
  - The final result is sign-extended from bit 31 (SLLW/SRLW/SRAW semantics).
- Not defined: the word input is ignored (treated as 0). No masking or extension logic is synthesized.

Decomposition:
- Package shift_pkg:
  - enum shift_op_t {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_RSVD}
  - enum shift_state_t {IDLE, BUSY, DONE}
- Sub-module shift_step: combinational single-cycle shifter.
  - Inputs: data N, amount $clog2(STEP)+1 bits (0..STEP), direction, fill bit.
  - Built as a mux2 stage chain.
- shift_seq holds the FSM, remaining counter, working register and handshakes.

Test Plan:
- Defaults N=64, STEP=8. SRL 0x8000_0000_0000_0000 by 63 -> dataOut=0x1, result_valid first high in cycle 9, busy high cycles 1-9.
- SRA 0xF000_0000_0000_0000 by 4 -> 0xFF00_0000_0000_0000 in cycle 2. SRL of the same operand by 4 -> 0x0F00_0000_0000_0000.
- SLL 0x1 by 0 -> 0x1 in cycle 1. op=11 with 0x1234 by 17 -> 0x1234 in cycle 1.
- SHIFT_WORD_OPS_EN: SLLW 0x0000_0000_4000_0001 by 1 -> 0xFFFF_FFFF_8000_0002. SRAW 0x0000_0000_8000_0000 by 33 (masked to 1) -> 0xFFFF_FFFF_C000_0000.
- Back-pressure: hold result_ready=0 for 5 cycles in DONE. result_valid and dataOut stay stable and start_ready=0. Assert start_valid during this window -> no accept.
- Assert rst in cycle 3 of an SLL by 40 -> all outputs at reset values immediately. Next request (SLL 0x3 by 8) -> 0x300 in cycle 2.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift sequencer (shift_seq) and its step shifter.
// Optional RV64 word forms are enabled in shift_seq by defining SHIFT_WORD_OPS_EN.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } shift_state_t;

  function automatic logic op_is_right(input shift_op_t op);
    return (op == SHIFT_SRL) || (op == SHIFT_SRA);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-cycle shifter: moves data by 0..STEP positions in either
// direction, built as a chain of power-of-two mux2 stages.
module shift_step #(
  parameter int N    = 64,
  parameter int STEP = 8
) (
  input  logic [N-1:0]             data,
  input  logic [$clog2(STEP):0]    amount,
  input  logic                     dir,
  input  logic                     fill,
  output logic [N-1:0]             result
);

  localparam int SW = $clog2(STEP) + 1;

  logic [SW:0][N-1:0] stage;

  assign stage[0] = data;

  // Stage gi shifts by 2**gi when amount bit gi is set; dir=1 shifts right.
  generate
    for (genvar gi = 0; gi < SW; gi++) begin : g_stage
      localparam int S = 1 << gi;
      logic [N-1:0] shl;
      logic [N-1:0] shr;
      assign shl = {stage[gi][N-1-S:0], {S{fill}}};
      assign shr = {{S{fill}}, stage[gi][N-1:S]};
      assign stage[gi+1] = amount[gi] ? (dir ? shr : shl) : stage[gi];
    end
  endgenerate

  assign result = stage[SW];

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle SLL/SRL/SRA sequencer applying up to STEP positions per cycle.
// Define SHIFT_WORD_OPS_EN to add the RV64 SLLW/SRLW/SRAW forms via the word input.
module shift_seq
  import shift_pkg::*;
#(
  parameter int N    = 64,
  parameter int STEP = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [1:0]            op,
  input  logic                  word,
  input  logic [$clog2(N)-1:0]  shift_amount,
  input  logic [N-1:0]          dataIn,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [N-1:0]          dataOut,
  output logic                  busy
);

  localparam int AW = $clog2(N);
  localparam int SW = $clog2(STEP) + 1;

  shift_state_t   state_reg;
  shift_op_t      op_reg;
  logic [N-1:0]   work_reg;
  logic [AW-1:0]  remaining_reg;

  logic [AW-1:0]  eff_amount;
  logic [N-1:0]   pre_data;
  logic [N-1:0]   accept_result;
  logic [N-1:0]   final_result;
  logic [SW-1:0]  step;
  logic [N-1:0]   step_out;
  logic           step_fill;
  logic           step_dir;

`ifdef SHIFT_WORD_OPS_EN
  logic word_reg;

  function automatic logic [N-1:0] sext32(input logic [N-1:0] v);
    return {{(N-32){v[31]}}, v[31:0]};
  endfunction
`else
  logic unused_word;
  assign unused_word = word;
`endif

  // Operand conditioning at accept time; word forms mask the amount and narrow the operand.
  always_comb begin
    eff_amount    = shift_amount;
    pre_data      = dataIn;
`ifdef SHIFT_WORD_OPS_EN
    if (word) begin
      eff_amount = {{(AW-5){1'b0}}, shift_amount[4:0]};
      case (op)
        2'b01:   pre_data = {{(N-32){1'b0}}, dataIn[31:0]};
        2'b10:   pre_data = {{(N-32){dataIn[31]}}, dataIn[31:0]};
        default: pre_data = dataIn;
      endcase
    end
`endif
    accept_result = pre_data;
`ifdef SHIFT_WORD_OPS_EN
    if (word) begin
      accept_result = sext32(pre_data);
    end
`endif
  end

  always_comb begin
    if (remaining_reg >= AW'(STEP)) begin
      step = SW'(STEP);
    end else begin
      step = remaining_reg[SW-1:0];
    end
  end

  assign step_dir  = op_is_right(op_reg);
  assign step_fill = (op_reg == SHIFT_SRA) & work_reg[N-1];

  shift_step #(
    .N    (N),
    .STEP (STEP)
  ) u_step (
    .data   (work_reg),
    .amount (step),
    .dir    (step_dir),
    .fill   (step_fill),
    .result (step_out)
  );

  always_comb begin
    final_result = step_out;
`ifdef SHIFT_WORD_OPS_EN
    if (word_reg) begin
      final_result = sext32(step_out);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_reg        <= SHIFT_SLL;
      work_reg      <= '0;
      remaining_reg <= '0;
      dataOut       <= '0;
      result_valid  <= 1'b0;
      busy          <= 1'b0;
      start_ready   <= 1'b1;
`ifdef SHIFT_WORD_OPS_EN
      word_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_valid && start_ready) begin
            op_reg      <= shift_op_t'(op);
            work_reg    <= pre_data;
            start_ready <= 1'b0;
            busy        <= 1'b1;
`ifdef SHIFT_WORD_OPS_EN
            word_reg    <= word;
`endif
            // Nothing to shift: the operand goes straight to the result register.
            if ((eff_amount == '0) || (op == 2'b11)) begin
              remaining_reg <= '0;
              dataOut       <= accept_result;
              result_valid  <= 1'b1;
              state_reg     <= DONE;
            end else begin
              remaining_reg <= eff_amount;
              state_reg     <= BUSY;
            end
          end
        end

        BUSY: begin
          work_reg      <= step_out;
          remaining_reg <= remaining_reg - AW'(step);
          if (remaining_reg == AW'(step)) begin
            dataOut      <= final_result;
            result_valid <= 1'b1;
            state_reg    <= DONE;
          end
        end

        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
            state_reg    <= IDLE;
          end
        end

        default: begin
          state_reg    <= IDLE;
          result_valid <= 1'b0;
          busy         <= 1'b0;
          start_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: directed requests push expected results and
// latencies; a negedge monitor pops and compares when results are presented.
module tb_shift_seq;

  localparam int N = 64;
  localparam int STEP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [1:0]    op = 2'b00;
  logic          word = 1'b0;
  logic [5:0]    shift_amount = '0;
  logic [N-1:0]  dataIn = '0;
  logic          result_valid;
  logic          result_ready = 1'b1;
  logic [N-1:0]  dataOut;
  logic          busy;

  shift_seq #(.N(N), .STEP(STEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .word         (word),
    .shift_amount (shift_amount),
    .dataIn       (dataIn),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .dataOut      (dataOut),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          negcnt = 0;
  int          busycnt = 0;
  int          txn = 0;
  bit          seen = 0;
  logic [63:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: one comparison set per presented result.
  always @(negedge clk) begin
    negcnt++;
    if (rst) begin
      seen = 0;
      busycnt = 0;
    end else begin
      if (busy && q.size() > 0) busycnt++;
      if (result_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got dataOut=%h, expected no result", dataOut);
        end else begin
          if (!seen) begin
            seen = 1;
            held = dataOut;
            check("latency", 64'(negcnt - q[0].acc), 64'(q[0].lat));
            check("dataOut", dataOut, q[0].data);
          end else begin
            check("hold_dataOut", dataOut, held);
          end
          if (!result_ready) begin
            check("start_ready_in_done", 64'(start_ready), 64'd0);
          end else begin
            check("busy_cycles", 64'(busycnt), 64'(negcnt - q[0].acc));
            $display("txn %0d: dataOut=%h latency=%0d busy_cycles=%0d",
                     txn, dataOut, negcnt - q[0].acc, busycnt);
            txn++;
            void'(q.pop_front());
            seen = 0;
            busycnt = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic w, input int amt, input logic [63:0] d,
                       input logic [63:0] exp, input int lat, input bit track);
    int n = 0;
    @(negedge clk);
    while (!start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got start_ready=0, expected 1");
      return;
    end
    op = o;
    word = w;
    shift_amount = amt[5:0];
    dataIn = d;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    if (track) q.push_back('{data: exp, lat: lat, acc: negcnt});
    // Scramble inputs while busy; they must be ignored.
    op = 2'b11;
    word = ~w;
    shift_amount = 6'h2a;
    dataIn = 64'hDEAD_BEEF_CAFE_F00D;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_dataOut", dataOut, 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_start_ready", 64'(start_ready), 64'd1);
    #2 rst = 1'b0;

    issue(2'b01, 0, 63, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 9, 1);
    issue(2'b10, 0, 4,  64'hF000_0000_0000_0000, 64'hFF00_0000_0000_0000, 2, 1);
    issue(2'b01, 0, 4,  64'hF000_0000_0000_0000, 64'h0F00_0000_0000_0000, 2, 1);
    issue(2'b00, 0, 0,  64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1, 1);
    issue(2'b11, 0, 17, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1234, 1, 1);
    issue(2'b10, 0, 63, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 9, 1);
    issue(2'b00, 0, 63, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 9, 1);
    issue(2'b10, 0, 9,  64'h7FFF_FFFF_FFFF_FFFF, 64'h003F_FFFF_FFFF_FFFF, 3, 1);
    issue(2'b00, 0, 12, 64'h0000_0000_0000_1234, 64'h0000_0000_0123_4000, 3, 1);
    issue(2'b00, 0, 8,  64'h0000_0000_0000_0003, 64'h0000_0000_0000_0300, 2, 1);
`ifdef SHIFT_WORD_OPS_EN
    issue(2'b00, 1, 1,  64'h0000_0000_4000_0001, 64'hFFFF_FFFF_8000_0002, 2, 1);
    issue(2'b10, 1, 33, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_C000_0000, 2, 1);
    issue(2'b01, 1, 33, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 2, 1);
    issue(2'b01, 1, 0,  64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 1, 1);
`else
    issue(2'b01, 1, 33, 64'h8000_0000_0000_0000, 64'h0000_0000_4000_0000, 6, 1);
    issue(2'b00, 1, 1,  64'h0000_0000_4000_0001, 64'h0000_0000_8000_0002, 2, 1);
`endif
    drain();

    // Back-pressure: hold the result for 5 cycles while a request is offered.
    @(posedge clk);
    #1 result_ready = 1'b0;
    issue(2'b10, 0, 4, 64'hF000_0000_0000_0000, 64'hFF00_0000_0000_0000, 2, 1);
    n = 0;
    while (!result_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_result_valid", 64'(result_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      op = 2'b00;
      word = 1'b0;
      shift_amount = 6'd1;
      dataIn = 64'h0000_0000_0000_00FF;
      start_valid = 1'b1;
      @(negedge clk);
    end
    start_valid = 1'b0;
    @(posedge clk);
    #1 result_ready = 1'b1;
    drain();

    // Reset in cycle 3 of a long SLL aborts it with no result.
    issue(2'b00, 0, 40, 64'h0000_0000_0000_0005, 64'd0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_dataOut", dataOut, 64'd0);
    check("abort_result_valid", 64'(result_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_start_ready", 64'(start_ready), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    issue(2'b00, 0, 8, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0300, 2, 1);
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
